// File: rtl/io_hub_pkg.sv
// Shared constants for the CPU IO hub: word indices on the IO bus and
// status/control bit positions.
package io_hub_pkg;
  localparam logic [3:0] W_MS   = 4'd0;
  localparam logic [3:0] W_SWI  = 4'd1;
  localparam logic [3:0] W_RX   = 4'd2;
  localparam logic [3:0] W_STAT = 4'd3;
  localparam logic [3:0] W_CMP  = 4'd4;
  localparam logic [3:0] W_CNT  = 4'd5;

  // status read bits
  localparam int ST_RXNE   = 0;
  localparam int ST_TXRDY  = 1;
  localparam int ST_FULL   = 2;
  localparam int ST_TXDROP = 3;
  localparam int ST_PEND   = 4;
  localparam int ST_EN     = 5;

  // control write bits
  localparam int CT_EN       = 0;
  localparam int CT_CLR_PEND = 1;
  localparam int CT_CLR_DROP = 2;
endpackage

// File: rtl/io_rx_fifo.sv
// Byte FIFO buffering UART receive data until the CPU reads it.
// DEPTH must be a power of two so the pointers wrap naturally.
module io_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // storage needs no reset: contents are only visible when count > 0
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end
endmodule

// File: rtl/io_hub.sv
// CPU IO hub: ms timer with compare interrupt, LEDs, switches, UART RX FIFO
// and TX launch behind a 16-word IO map.
module io_hub
  import io_hub_pkg::*;
#(
  parameter int TICK_DIV  = 25000,
  parameter int LED_W     = 8,
  parameter int SWI_W     = 8,
  parameter int RXF_DEPTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             iord,
  input  logic             iowr,
  input  logic [5:0]       ioadr,
  input  logic [31:0]      outbus,
  output logic [31:0]      inbus,
  input  logic [SWI_W-1:0] swi,
  output logic [LED_W-1:0] leds,
  input  logic [7:0]       rx_data,
  input  logic             rx_rdy,
  output logic             rx_done,
  output logic [7:0]       tx_data,
  output logic             tx_start,
  input  logic             tx_rdy,
  output logic             irq
);
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int CW = $clog2(RXF_DEPTH) + 1;

  logic [3:0]       word;
  logic             wr_ms, wr_led, wr_rx, wr_stat, wr_cmp, rd_rx;
  logic [PW-1:0]    presc;
  logic [31:0]      ms, cmp;
  logic             tick, pend_set, pend_clr;
  logic             irq_en, irq_pend, tx_drop;
  logic [SWI_W-1:0] swi_s1, swi_s2;
  logic             push, pop;
  logic [7:0]       rx_head;
  logic [CW-1:0]    rx_count;
  logic             rx_full, rx_empty;
  logic [31:0]      status;
  logic             unused_adr;

  assign word       = ioadr[5:2];
  assign unused_adr = ^ioadr[1:0];
  assign wr_ms      = iowr && word == W_MS;
  assign wr_led     = iowr && word == W_SWI;
  assign wr_rx      = iowr && word == W_RX;
  assign wr_stat    = iowr && word == W_STAT;
  assign wr_cmp     = iowr && word == W_CMP;
  assign rd_rx      = iord && word == W_RX;

  assign tick     = (presc == PW'(TICK_DIV - 1));
  // a clearing write suppresses the increment, so it cannot raise the interrupt
  assign pend_set = tick && !wr_ms && (cmp != '0) && (ms + 32'd1 == cmp);
  assign pend_clr = wr_stat && outbus[CT_CLR_PEND];

  assign push = rx_rdy & ~rx_done & ~rx_full;
  assign pop  = rd_rx & ~rx_empty;

  assign tx_data  = outbus[7:0];
  assign tx_start = wr_rx & tx_rdy;
  assign irq      = irq_pend & irq_en;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      presc    <= '0;
      ms       <= '0;
      cmp      <= '0;
      leds     <= '0;
      irq_en   <= 1'b0;
      irq_pend <= 1'b0;
      tx_drop  <= 1'b0;
      rx_done  <= 1'b0;
      swi_s1   <= '0;
      swi_s2   <= '0;
    end else begin
      if (wr_ms) begin
        presc <= '0;
        ms    <= '0;
      end else if (tick) begin
        presc <= '0;
        ms    <= ms + 32'd1;
      end else begin
        presc <= presc + 1'b1;
      end
      if (wr_cmp) cmp    <= outbus;
      if (wr_led) leds   <= outbus[LED_W-1:0];
      if (wr_stat) irq_en <= outbus[CT_EN];
      irq_pend <= pend_set | (irq_pend & ~pend_clr);
      tx_drop  <= (wr_rx & ~tx_rdy) | (tx_drop & ~(wr_stat & outbus[CT_CLR_DROP]));
      rx_done  <= push;
      swi_s1   <= swi;
      swi_s2   <= swi_s1;
    end
  end

  io_rx_fifo #(.WIDTH(8), .DEPTH(RXF_DEPTH)) u_rx_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (rx_data),
    .dout  (rx_head),
    .count (rx_count),
    .full  (rx_full),
    .empty (rx_empty)
  );

  always_comb begin
    status            = '0;
    status[ST_RXNE]   = ~rx_empty;
    status[ST_TXRDY]  = tx_rdy;
    status[ST_FULL]   = rx_full;
    status[ST_TXDROP] = tx_drop;
    status[ST_PEND]   = irq_pend;
    status[ST_EN]     = irq_en;
  end

  always_comb begin
    inbus = '0;
    if (iord) begin
      case (word)
        W_MS:    inbus = ms;
        W_SWI:   inbus = 32'(swi_s2);
        W_RX:    inbus = rx_empty ? 32'd0 : 32'(rx_head);
        W_STAT:  inbus = status;
        W_CMP:   inbus = cmp;
        W_CNT:   inbus = 32'(rx_count);
        default: inbus = '0;
      endcase
    end
  end
endmodule
